// File: rtl/cen_gen.sv
// Fractional-N clock-enable generator: CHANNELS independent N/M accumulators plus a config-lock flag.
// Optional macro CEN_GEN_TOGGLE_EN adds a per-channel divide-by-two square wave on tog.
module cen_gen #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic [CHANNELS*ACC_W-1:0] num,
  input  logic [CHANNELS*ACC_W-1:0] den,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       cen,
  output logic [CHANNELS-1:0]       tog,
  output logic                      locked
);

  localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

  logic [CHANNELS*ACC_W-1:0] num_q;
  logic [CHANNELS*ACC_W-1:0] den_q;
  logic [CHANNELS-1:0]       chg;
  logic [CHANNELS-1:0]       cen_nx;
  logic [LCW-1:0]            lock_cnt;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      den_q <= '0;
    end else begin
      num_q <= num;
      den_q <= den;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [ACC_W-1:0] n;
    logic [ACC_W-1:0] m;
    logic [ACC_W:0]   acc;
    logic [ACC_W:0]   acc_nx;
    logic [ACC_W:0]   base;
    logic [ACC_W:0]   sum;
    logic             cen_k;

    assign n      = num[k*ACC_W +: ACC_W];
    assign m      = den[k*ACC_W +: ACC_W];
    assign chg[k] = (n != num_q[k*ACC_W +: ACC_W]) || (m != den_q[k*ACC_W +: ACC_W]);
    assign cen_nx[k] = cen_k;

    // A config change restarts from phase 0 but still accumulates the new N on that
    // same edge, so a fresh config behaves exactly like the first edge after reset.
    always_comb begin
      acc_nx = '0;
      cen_k  = 1'b0;
      base   = chg[k] ? '0 : acc;
      sum    = base + {1'b0, n};
      if (sync || n == '0 || m == '0) begin
        acc_nx = '0;
        cen_k  = 1'b0;
      end else if (n >= m) begin
        acc_nx = '0;
        cen_k  = 1'b1;
      end else if (sum >= {1'b0, m}) begin
        acc_nx = sum - {1'b0, m};
        cen_k  = 1'b1;
      end else begin
        acc_nx = sum;
        cen_k  = 1'b0;
      end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else        acc <= acc_nx;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) cen <= '0;
    else        cen <= cen_nx;
  end

  // Sync and a config change on the same edge collapse into a single clear.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (sync || (|chg)) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LCW'(LOCK_CYCLES)) begin
      lock_cnt <= lock_cnt + LCW'(1);
    end
  end

  assign locked = (lock_cnt == LCW'(LOCK_CYCLES));

`ifdef CEN_GEN_TOGGLE_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) tog <= '0;
    else        tog <= (tog ^ cen) & ~(chg | {CHANNELS{sync}});
  end
`else
  assign tog = '0;
`endif

endmodule

// File: doc/cen_gen.md
CEN_GEN -- requirements
Module: cen_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent clock-enable channels (1..16).
REQ-002 SHALL have parameter ACC_W, default 16: width of each channel's numerator, denominator and accumulator.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: stable cycles required before locked asserts (1..65535).
REQ-004 SHALL have port refclk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port num, input, CHANNELS*ACC_W: per-channel increment N; channel k occupies bits [k*ACC_W +: ACC_W].
REQ-007 SHALL have port den, input, CHANNELS*ACC_W: per-channel modulus M, packed the same way as num.
REQ-008 SHALL have port sync, input, 1: one-cycle request to phase-align all channels.
REQ-009 SHALL have port cen, output, CHANNELS: registered per-channel clock-enable pulses.
REQ-010 SHALL have port tog, output, CHANNELS: per-channel square wave at half the cen rate (see REQ-026).
REQ-011 SHALL have port locked, output, 1: configuration has been stable for LOCK_CYCLES cycles.

Function
REQ-012 Each channel SHALL hold an internal accumulator acc of ACC_W+1 bits, so acc+N cannot overflow.
REQ-013 Each edge, active channel (0<N<M): sum=acc+N; if sum>=M then acc<=sum-M and cen<=1, else acc<=sum and cen<=0.
REQ-014 Average cen rate SHALL be exactly fclk*N/M, with pulse spacing differing by at most one cycle.
REQ-015 Latency: cen SHALL be registered and assert on the same edge at which the threshold is crossed; there is no combinational path from inputs to cen.
REQ-016 N==0 or M==0: channel idle, cen=0, acc held at 0.
REQ-017 N>=M (with M!=0): cen SHALL be held at 1 every cycle and acc held at 0.
REQ-018 sync=1: all accumulators SHALL clear to 0 and all cen SHALL be 0 on that edge; accumulation resumes on the following edge.
REQ-019 num/den SHALL be registered internally each cycle; any difference between the registered and current value on any channel is a config change.
REQ-020 On a config change the affected channel's acc SHALL clear to 0, so it restarts from phase 0.
REQ-021 The lock counter SHALL count 0..LOCK_CYCLES and saturate; locked=1 exactly when the counter equals LOCK_CYCLES.
REQ-022 A config change or sync SHALL clear the lock counter and deassert locked on the next edge.
REQ-023 When sync and a config change occur on the same edge, they SHALL produce one clear, with no double counting.
REQ-024 Channels SHALL be fully independent; a config change on channel j SHALL leave channel k's acc and cen undisturbed.

Reset
REQ-025 While rst_n=0 (asynchronous): acc=0, cen=0, tog=0, lock counter=0, locked=0, and registered num/den=0; the first edge after release compares against 0, which counts as a config change for any channel with nonzero inputs.

Configuration
REQ-026 Macro CEN_GEN_TOGGLE_EN defined: each tog[k] SHALL flip on every edge where cen[k]=1 and clear on sync or on a config change of channel k.
REQ-027 Macro CEN_GEN_TOGGLE_EN undefined: tog SHALL be constant 0 and no toggle flops SHALL be synthesised.

Verification
REQ-028 Channel 0 with N=12, M=25, held stable for 250 cycles -> exactly 120 cen pulses, gaps of 2 or 3 cycles.
REQ-029 Channel 1 with N=1, M=2 from reset -> cen=0,1,0,1... with the first pulse on edge 2 after release; channel with N=2, M=25 -> 2 pulses per 25 cycles.
REQ-030 Static config -> locked rises on edge LOCK_CYCLES+1 after reset release; changing den[2] mid-run -> locked=0 next edge and channel 2 restarts from phase 0 while channels 0, 1 and 3 are unaffected.
REQ-031 N=5, M=3 -> cen constantly 1; N=0 or M=0 -> cen constantly 0; N=M=65535 (ACC_W=16) -> cen constantly 1 with no overflow.
REQ-032 sync pulsed mid-run with channels at N=1, M=4 and N=3, M=8 -> all cen=0 that edge, then identical pulse trains to those from reset; locked drops and relocks after LOCK_CYCLES.
REQ-033 With CEN_GEN_TOGGLE_EN defined, N=1, M=2 -> tog period 4 cycles at 50% duty; with the macro undefined -> tog stays 0; rst_n asserted mid-run -> all outputs 0 immediately, without waiting for a clock edge.
